// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and PC helper for the fetch front end
package fetch_pkg;

   localparam int ILEN        = 32;
   localparam int INSTR_BYTES = 4;
   localparam int PC_W        = 32;

   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [PC_W-1:0] pc;
   } fetch_entry_t;

   // Sequential PC advance; wraps naturally at 2^PC_W.
   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + PC_W'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry instruction/PC FIFO with flush
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset_l,
   input  logic         i_push,
   input  fetch_entry_t i_data,
   input  logic         i_pop,
   input  logic         i_flush,
   output fetch_entry_t o_head,
   output logic         o_empty,
   output logic [AW:0]  o_count
);

   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   fetch_entry_t r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   // Extra pointer MSB distinguishes full from empty.
   assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_empty = (r_wr_ptr == r_rd_ptr);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, credit-limited imem requester and redirect/drop logic
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
   parameter int               DEPTH        = 4
) (
   input  logic             clk,
   input  logic             reset_l,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_pc_plus4
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_rsp_pc;
   logic [AW:0]     r_outstanding;
   logic [AW:0]     r_drop_cnt;
   logic            r_req_valid;
   fetch_entry_t    r_hold;

   logic            w_req_hs;
   logic            w_push;
   logic            w_pop;
   logic            w_drop;
   logic            w_empty;
   logic [AW:0]     w_count;
   logic [AW:0]     w_out_nxt;
   logic [AW:0]     w_occ_nxt;
   logic            w_credit;
   logic [XLEN-1:0] w_redirect_pc;
   fetch_entry_t    w_head;
   fetch_entry_t    w_push_data;

   assign w_redirect_pc = redirect_pc & ~XLEN'(3);
   assign w_req_hs      = r_req_valid & imem_req_ready;
   assign w_drop        = imem_rsp_valid & (r_drop_cnt != '0);
   assign w_push        = imem_rsp_valid & (r_drop_cnt == '0) & ~redirect_valid;
   assign w_pop         = ~w_empty & out_ready;
   assign w_push_data   = '{instr: imem_rsp_data, pc: r_rsp_pc};

   always_comb begin
      w_out_nxt = r_outstanding;
      if (w_req_hs && !imem_rsp_valid)      w_out_nxt = r_outstanding + CNT_ONE;
      else if (!w_req_hs && imem_rsp_valid) w_out_nxt = r_outstanding - CNT_ONE;

      w_occ_nxt = w_count;
      if (redirect_valid)          w_occ_nxt = '0;
      else if (w_push && !w_pop)   w_occ_nxt = w_count + CNT_ONE;
      else if (!w_push && w_pop)   w_occ_nxt = w_count - CNT_ONE;
   end

   // Request valid is registered from next-state credit so it never sees redirect combinationally.
   assign w_credit = ({1'b0, w_out_nxt} + {1'b0, w_occ_nxt}) < (AW+2)'(DEPTH);

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_fetch_pc    <= RESET_VECTOR;
         r_rsp_pc      <= RESET_VECTOR;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_req_valid   <= 1'b0;
         r_hold        <= '{instr: '0, pc: RESET_VECTOR};
      end else begin
         r_outstanding <= w_out_nxt;
         r_req_valid   <= w_credit;
         if (!w_empty) r_hold <= w_head;
         if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_drop_cnt <= w_out_nxt;
         end else begin
            if (w_req_hs) r_fetch_pc <= pc_inc(r_fetch_pc);
            if (w_push)   r_rsp_pc   <= pc_inc(r_rsp_pc);
            if (w_drop)   r_drop_cnt <= r_drop_cnt - CNT_ONE;
         end
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk     (clk),
      .reset_l (reset_l),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign out_valid      = ~w_empty;
   assign out_instr      = w_empty ? r_hold.instr : w_head.instr;
   assign out_pc         = w_empty ? r_hold.pc    : w_head.pc;
   assign out_pc_plus4   = pc_inc(out_pc);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against an epoch-based reference model
module tb_fetch_unit;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RV    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_l = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;

   fetch_unit #(.XLEN(32), .RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset_l        (reset_l),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   req_t        pend[$];
   logic [31:0] sb_pc[$];
   logic [31:0] pops[$];
   logic [31:0] accs[$];
   logic [31:0] exp_req_pc;
   int          epoch, cyc, lat_lo, lat_hi;
   int          n_acc, n_disc, first_acc, first_ov;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      sb_pc.delete();
      accs.delete();
      exp_req_pc = RV;
      epoch      = 0;
   endtask

   task automatic step(input bit rdr, input logic [31:0] rpc, input bit ordy, input bit qrdy);
      bit   rsp, hs, pop;
      req_t r;
      int   due;
      @(negedge clk);
      cyc++;
      rsp            = (pend.size() > 0) && (pend[0].due <= cyc);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? mem_f(pend[0].addr) : $urandom;
      imem_req_ready = qrdy;
      out_ready      = ordy;
      redirect_valid = rdr;
      redirect_pc    = rdr ? rpc : $urandom;
      #1;
      chk("req_valid", 32'(imem_req_valid), 32'((pend.size() + sb_pc.size()) < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(sb_pc.size() > 0));
      if (sb_pc.size() > 0 && out_valid) begin
         chk("out_pc", out_pc, sb_pc[0]);
         chk("out_instr", out_instr, mem_f(sb_pc[0]));
         chk("out_pc_plus4", out_pc_plus4, sb_pc[0] + 32'd4);
      end
      hs  = imem_req_valid && qrdy;
      pop = out_valid && ordy;
      if (hs) chk("req_addr", imem_req_addr, exp_req_pc);
      if (hs && first_acc < 0) first_acc = cyc;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (pop && sb_pc.size() > 0) pops.push_back(sb_pc.pop_front());
      if (rsp) begin
         r = pend.pop_front();
         if (r.epoch == epoch && !rdr) sb_pc.push_back(r.addr);
         else n_disc++;
      end
      if (hs) begin
         due = cyc + $urandom_range(lat_hi, lat_lo);
         if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
         pend.push_back('{addr: exp_req_pc, epoch: epoch, due: due});
         accs.push_back(exp_req_pc);
         exp_req_pc += 32'd4;
         n_acc++;
      end
      if (rdr) begin
         epoch++;
         sb_pc.delete();
         exp_req_pc = rpc & ~32'd3;
      end
   endtask

   initial begin
      int a0, d0;
      cyc = 0; lat_lo = 1; lat_hi = 1;
      n_acc = 0; n_disc = 0; first_acc = -1; first_ov = -1;
      model_reset();
      #1 reset_l = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc", out_pc, RV);
      chk("rst_out_pc_plus4", out_pc_plus4, RV + 32'd4);
      @(negedge clk);
      reset_l = 1'b1;

      // Streaming with single-cycle memory.
      repeat (12) step(0, 0, 1, 1);
      chk("first_latency", 32'(first_ov - first_acc), 32'd2);
      chk("stream_accs", 32'(accs.size()), 32'd12);

      // Redirect colliding with a handshake and a response.
      d0 = n_disc;
      step(1, 32'h40, 1, 1);
      repeat (4) step(0, 0, 1, 1);
      chk("collide_disc", 32'(n_disc - d0), 32'd2);

      // Backpressure fills the queue, then a single pop frees one credit.
      step(1, 32'h200, 0, 1);
      a0 = n_acc;
      repeat (10) step(0, 0, 0, 1);
      chk("bp_accepts", 32'(n_acc - a0), 32'd4);
      a0 = n_acc;
      step(0, 0, 1, 1);
      repeat (6) step(0, 0, 0, 1);
      chk("bp_one_more", 32'(n_acc - a0), 32'd1);

      // Three outstanding on 3-cycle memory, then redirect.
      for (int i = 0; i < 20; i++)
         if (pend.size() > 0 || sb_pc.size() > 0) step(0, 0, 1, 0);
      chk("drained", 32'(pend.size() + sb_pc.size()), 32'd0);
      lat_lo = 3; lat_hi = 3;
      repeat (3) step(0, 0, 1, 1);
      d0 = n_disc;
      step(1, 32'h100, 1, 0);
      pops.delete();
      repeat (12) step(0, 0, 1, 1);
      chk("lat3_disc", 32'(n_disc - d0), 32'd3);
      chk("lat3_npops", 32'(pops.size() >= 2), 32'd1);
      if (pops.size() >= 2) begin
         chk("lat3_pop0", pops[0], 32'h100);
         chk("lat3_pop1", pops[1], 32'h104);
      end

      // Redirect near the top of the address space.
      lat_lo = 1; lat_hi = 1;
      step(1, 32'hFFFF_FFFE, 1, 1);
      pops.delete();
      accs.delete();
      repeat (6) step(0, 0, 1, 1);
      chk("wrap_naccs", 32'(accs.size() >= 2), 32'd1);
      if (accs.size() >= 2) begin
         chk("wrap_acc0", accs[0], 32'hFFFF_FFFC);
         chk("wrap_acc1", accs[1], 32'h0000_0000);
      end
      chk("wrap_npops", 32'(pops.size() >= 1), 32'd1);
      if (pops.size() >= 1) chk("wrap_pop0", pops[0], 32'hFFFF_FFFC);

      // Random traffic with variable latency and sporadic redirects.
      lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0);

      // Fill the queue, then reset asynchronously mid-cycle.
      lat_lo = 1; lat_hi = 1;
      repeat (12) step(0, 0, 0, 1);
      chk("full_occ", 32'(sb_pc.size()), 32'(DEPTH));
      @(negedge clk);
      #2 reset_l = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_req_valid", 32'(imem_req_valid), 32'd0);
      chk("async_out_pc", out_pc, RV);
      chk("async_out_instr", out_instr, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_l = 1'b1;
      model_reset();
      repeat (8) step(0, 0, 1, 1);
      chk("restart_naccs", 32'(accs.size() >= 1), 32'd1);
      if (accs.size() >= 1) chk("restart_addr", accs[0], RV);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
